// File: rtl/uart_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Package : uart_pkg
// Parity selectors, receiver FSM encoding and baud-period helper.
// Rev     : 1.0
// ----------------------------------------------------------------------------
package uart_pkg;

    localparam int unsigned PARITY_NONE = 0;
    localparam int unsigned PARITY_ODD  = 1;
    localparam int unsigned PARITY_EVEN = 2;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } rx_state_t;

    function automatic int unsigned bit_cyc(input int unsigned clk_hz,
                                            input int unsigned baud);
        return clk_hz / baud;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module  : sync_fifo
// Show-ahead synchronous FIFO; a push into a full FIFO only lands if the
// same cycle also pops.
// Rev     : 1.0
// ----------------------------------------------------------------------------
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_wr_data,
    output logic [WIDTH-1:0] o_rd_data,
    output logic             o_full,
    output logic             o_empty
);

    localparam int c_AW = $clog2(DEPTH);
    localparam logic [c_AW:0] c_FULL_CNT = (c_AW + 1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_AW-1:0]  r_wr_ptr;
    logic [c_AW-1:0]  r_rd_ptr;
    logic [c_AW:0]    r_count;
    logic             w_push;
    logic             w_pop;

    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == c_FULL_CNT);
    assign w_pop     = i_pop & ~o_empty;
    assign w_push    = i_push & (~o_full | w_pop);
    // Head word is forced to zero while empty so the port never shows stale data.
    assign o_rd_data = o_empty ? '0 : r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            unique case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_rx_fifo.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module  : uart_rx_fifo
// Oversampling UART receiver with optional parity, stop-bit check and a
// receive FIFO that the command decoder drains at its own pace.
// Rev     : 1.0
// ----------------------------------------------------------------------------
module uart_rx_fifo #(
    parameter int unsigned CLK_HZ     = 100_000_000,
    parameter int unsigned BAUD       = 9600,
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned PARITY     = 0,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    input  logic                 rd_en,
    output logic [DATA_BITS-1:0] rd_data,
    output logic                 rd_valid,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 overflow
);
    import uart_pkg::*;

    localparam int unsigned c_BIT_CYC  = bit_cyc(CLK_HZ, BAUD);
    localparam int unsigned c_HALF_CYC = c_BIT_CYC / 2;
    localparam int          c_CW       = $clog2(c_BIT_CYC);
    localparam int          c_BW       = $clog2(DATA_BITS + 1);
    localparam logic [c_CW-1:0] c_BIT_LAST  = c_CW'(c_BIT_CYC - 1);
    localparam logic [c_CW-1:0] c_HALF_LAST = c_CW'(c_HALF_CYC - 1);
    localparam logic [c_BW-1:0] c_DATA_LAST = c_BW'(DATA_BITS - 1);

    logic                 r_sync1;
    logic                 r_sync2;
    logic                 r_rx_prev;
    logic                 w_start_edge;
    rx_state_t            r_state;
    rx_state_t            w_state_nxt;
    logic [c_CW-1:0]      r_cyc_cnt;
    logic [c_BW-1:0]      r_bit_cnt;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_par_bad;
    logic                 r_frame_err;
    logic                 r_parity_err;
    logic                 r_overflow;
    logic                 w_bit_done;
    logic                 w_cyc_clr;
    logic                 w_shift_en;
    logic                 w_par_latch;
    logic                 w_stop_sample;
    logic                 w_push;
    logic                 w_full;
    logic                 w_empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1   <= 1'b1;
            r_sync2   <= 1'b1;
            r_rx_prev <= 1'b1;
        end else begin
            r_sync1   <= rx;
            r_sync2   <= r_sync1;
            r_rx_prev <= r_sync2;
        end
    end

    // Only a 1->0 transition starts a frame, so a line stuck low stays idle.
    assign w_start_edge = r_rx_prev & ~r_sync2;
    assign w_bit_done   = (r_cyc_cnt == c_BIT_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_cyc_clr     = 1'b0;
        w_shift_en    = 1'b0;
        w_par_latch   = 1'b0;
        w_stop_sample = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (w_start_edge) begin
                    w_state_nxt = ST_START;
                    w_cyc_clr   = 1'b1;
                end
            end
            ST_START: begin
                if (r_cyc_cnt == c_HALF_LAST) begin
                    w_cyc_clr   = 1'b1;
                    w_state_nxt = r_sync2 ? ST_IDLE : ST_DATA;
                end
            end
            ST_DATA: begin
                if (w_bit_done) begin
                    w_cyc_clr  = 1'b1;
                    w_shift_en = 1'b1;
                    if (r_bit_cnt == c_DATA_LAST) begin
                        w_state_nxt = (PARITY != PARITY_NONE) ? ST_PARITY : ST_STOP;
                    end
                end
            end
            ST_PARITY: begin
                if (w_bit_done) begin
                    w_cyc_clr   = 1'b1;
                    w_par_latch = 1'b1;
                    w_state_nxt = ST_STOP;
                end
            end
            ST_STOP: begin
                if (w_bit_done) begin
                    w_cyc_clr     = 1'b1;
                    w_stop_sample = 1'b1;
                    w_state_nxt   = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign w_push = w_stop_sample & r_sync2 & ~r_par_bad;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cyc_cnt    <= '0;
            r_bit_cnt    <= '0;
            r_shift      <= '0;
            r_par_bad    <= 1'b0;
            r_frame_err  <= 1'b0;
            r_parity_err <= 1'b0;
            r_overflow   <= 1'b0;
        end else begin
            if (w_cyc_clr || (r_state == ST_IDLE)) begin
                r_cyc_cnt <= '0;
            end else begin
                r_cyc_cnt <= r_cyc_cnt + 1'b1;
            end
            if (r_state == ST_IDLE) begin
                r_bit_cnt <= '0;
            end else if (w_shift_en) begin
                r_bit_cnt <= (r_bit_cnt == c_DATA_LAST) ? '0 : r_bit_cnt + 1'b1;
            end
            if (w_shift_en) begin
                r_shift <= {r_sync2, r_shift[DATA_BITS-1:1]};
            end
            // Odd parity wants the XOR over data and parity bit to be 1, even wants 0.
            if (r_state == ST_IDLE) begin
                r_par_bad <= 1'b0;
            end else if (w_par_latch) begin
                r_par_bad <= (^{r_shift, r_sync2}) != (PARITY == PARITY_ODD);
            end
            r_frame_err  <= w_stop_sample & ~r_sync2;
            r_parity_err <= w_stop_sample & r_sync2 & r_par_bad;
            r_overflow   <= w_push & w_full & ~rd_en;
        end
    end

    sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .i_push    (w_push),
        .i_pop     (rd_en),
        .i_wr_data (r_shift),
        .o_rd_data (rd_data),
        .o_full    (w_full),
        .o_empty   (w_empty)
    );

    assign rd_valid   = ~w_empty;
    assign frame_err  = r_frame_err;
    assign parity_err = r_parity_err;
    assign overflow   = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_fifo.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module  : tb_uart_rx_fifo
// Directed bench: a no-parity and an even-parity receiver, scoreboard queues.
// Rev     : 1.0
// ----------------------------------------------------------------------------
module tb_uart_rx_fifo;

    localparam int c_BIT = 32;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx0 = 1'b1;
    logic       rx1 = 1'b1;
    logic       rd_en0 = 1'b0;
    logic       rd_en1 = 1'b0;
    logic [7:0] rd_data0, rd_data1;
    logic       rd_valid0, rd_valid1;
    logic       frame_err0, frame_err1;
    logic       parity_err0, parity_err1;
    logic       overflow0, overflow1;

    int checks = 0;
    int errors = 0;
    int n_ferr0 = 0, n_perr0 = 0, n_ovf0 = 0;
    int n_ferr1 = 0, n_perr1 = 0, n_ovf1 = 0;
    logic [7:0] q0[$];
    logic [7:0] q1[$];

    always #5 clk = ~clk;

    uart_rx_fifo #(
        .CLK_HZ(3_200_000), .BAUD(100_000), .DATA_BITS(8), .PARITY(0), .FIFO_DEPTH(4)
    ) dut (
        .clk(clk), .rst(rst), .rx(rx0), .rd_en(rd_en0),
        .rd_data(rd_data0), .rd_valid(rd_valid0), .frame_err(frame_err0),
        .parity_err(parity_err0), .overflow(overflow0)
    );

    uart_rx_fifo #(
        .CLK_HZ(3_200_000), .BAUD(100_000), .DATA_BITS(8), .PARITY(2), .FIFO_DEPTH(4)
    ) dut_par (
        .clk(clk), .rst(rst), .rx(rx1), .rd_en(rd_en1),
        .rd_data(rd_data1), .rd_valid(rd_valid1), .frame_err(frame_err1),
        .parity_err(parity_err1), .overflow(overflow1)
    );

    // Pulses are registered and one cycle wide, so each is counted exactly once.
    always @(negedge clk) begin
        if (frame_err0)  n_ferr0++;
        if (parity_err0) n_perr0++;
        if (overflow0)   n_ovf0++;
        if (frame_err1)  n_ferr1++;
        if (parity_err1) n_perr1++;
        if (overflow1)   n_ovf1++;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_rx(input int which, input logic v);
        if (which == 0) rx0 = v;
        else            rx1 = v;
    endtask

    task automatic send(input int which, input logic [7:0] d, input bit with_par,
                        input logic par_bit, input logic stop_bit);
        set_rx(which, 1'b0);
        repeat (c_BIT) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            set_rx(which, d[i]);
            repeat (c_BIT) @(negedge clk);
        end
        if (with_par) begin
            set_rx(which, par_bit);
            repeat (c_BIT) @(negedge clk);
        end
        set_rx(which, stop_bit);
        repeat (c_BIT) @(negedge clk);
        set_rx(which, 1'b1);
    endtask

    task automatic send_good0(input logic [7:0] d);
        q0.push_back(d);
        send(0, d, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic pop_check(input int which, input string tag);
        logic       rv;
        logic [7:0] exp;
        rv = (which == 0) ? rd_valid0 : rd_valid1;
        for (int i = 0; i < 4 * c_BIT && !rv; i++) begin
            @(negedge clk);
            rv = (which == 0) ? rd_valid0 : rd_valid1;
        end
        check({tag, "_valid"}, {31'd0, rv}, 32'd1);
        if (which == 0) begin
            exp = (q0.size() > 0) ? q0.pop_front() : 8'hxx;
            check({tag, "_data"}, {24'd0, rd_data0}, {24'd0, exp});
            rd_en0 = 1'b1;
            @(negedge clk);
            rd_en0 = 1'b0;
        end else begin
            exp = (q1.size() > 0) ? q1.pop_front() : 8'hxx;
            check({tag, "_data"}, {24'd0, rd_data1}, {24'd0, exp});
            rd_en1 = 1'b1;
            @(negedge clk);
            rd_en1 = 1'b0;
        end
    endtask

    initial begin
        logic [7:0] par;
        logic [7:0] exp_head;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_valid0", {31'd0, rd_valid0}, 32'd0);
        check("rst_data0", {24'd0, rd_data0}, 32'd0);
        check("rst_errs0", {29'd0, frame_err0, parity_err0, overflow0}, 32'd0);
        check("rst_valid1", {31'd0, rd_valid1}, 32'd0);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        // Clean 0x5A, then pop empties the FIFO
        send_good0(8'h5A);
        check("5a_valid_after_stop", {31'd0, rd_valid0}, 32'd1);
        pop_check(0, "5a");
        check("5a_empty_after_pop", {31'd0, rd_valid0}, 32'd0);
        check("5a_no_errs", n_ferr0 + n_perr0 + n_ovf0, 32'd0);

        // Short low glitch must be rejected at the start-bit check
        rx0 = 1'b0;
        repeat (c_BIT / 4) @(negedge clk);
        rx0 = 1'b1;
        repeat (2 * c_BIT) @(negedge clk);
        check("glitch_valid", {31'd0, rd_valid0}, 32'd0);
        check("glitch_errs", n_ferr0 + n_perr0 + n_ovf0, 32'd0);
        send_good0(8'h3C);
        pop_check(0, "after_glitch");

        // Stop bit low: frame error, nothing stored; recovery with 0x11
        send(0, 8'hC3, 1'b0, 1'b0, 1'b0);
        repeat (c_BIT) @(negedge clk);
        check("c3_frame_err", n_ferr0, 32'd1);
        check("c3_not_pushed", {31'd0, rd_valid0}, 32'd0);
        send_good0(8'h11);
        pop_check(0, "11");

        // Even parity receiver: wrong parity bit, then correct one
        par = {7'd0, ^8'h07};
        send(1, 8'h07, 1'b1, ~par[0], 1'b1);
        repeat (2) @(negedge clk);
        check("par_bad_pulse", n_perr1, 32'd1);
        check("par_bad_not_pushed", {31'd0, rd_valid1}, 32'd0);
        q1.push_back(8'h07);
        send(1, 8'h07, 1'b1, par[0], 1'b1);
        pop_check(1, "par_good");
        check("par_ferr_none", n_ferr1, 32'd0);

        // Five back-to-back frames into a 4-deep FIFO
        for (int v = 1; v <= 4; v++) send_good0(8'(v));
        check("ovf_none_yet", n_ovf0, 32'd0);
        send(0, 8'h05, 1'b0, 1'b0, 1'b1);
        repeat (2) @(negedge clk);
        check("ovf_pulse_on_05", n_ovf0, 32'd1);
        for (int v = 0; v < 4; v++) pop_check(0, "ovf_drain");
        check("ovf_drained", {31'd0, rd_valid0}, 32'd0);

        // Full FIFO with a pop in the very cycle 0x06 is pushed
        for (int v = 1; v <= 4; v++) send_good0(8'(v));
        fork
            send(0, 8'h06, 1'b0, 1'b0, 1'b1);
            begin
                // Stop bit is sampled 306 cycles after the start bit is driven.
                repeat (306) @(negedge clk);
                exp_head = q0.pop_front();
                check("simul_head", {24'd0, rd_data0}, {24'd0, exp_head});
                rd_en0 = 1'b1;
                @(negedge clk);
                rd_en0 = 1'b0;
            end
        join
        q0.push_back(8'h06);
        repeat (2) @(negedge clk);
        check("simul_no_ovf", n_ovf0, 32'd1);
        for (int v = 0; v < 4; v++) pop_check(0, "simul_drain");
        check("simul_drained", {31'd0, rd_valid0}, 32'd0);

        // Reset mid-frame with a word waiting
        send_good0(8'h77);
        rx0 = 1'b0;
        repeat (3 * c_BIT) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("midrst_valid", {31'd0, rd_valid0}, 32'd0);
        check("midrst_data", {24'd0, rd_data0}, 32'd0);
        check("midrst_errs", {29'd0, frame_err0, parity_err0, overflow0}, 32'd0);
        q0.delete();
        rx0 = 1'b1;
        rst = 1'b0;
        repeat (12 * c_BIT) @(negedge clk);
        check("postrst_valid", {31'd0, rd_valid0}, 32'd0);
        check("postrst_ferr", n_ferr0, 32'd1);
        check("postrst_perr", n_perr0 + n_ovf1, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
